top_mul_share_ctrl: RTL and testbench
=====================================

// Module: top_mul_share_ctrl
// PURPOSE
//   Time-shares one signed 8x8->16 multiplier (top_mul_8s_8s_16_1_1) among NUM_REQ requesters.
//   Round-robin arbitration, valid/ready operand and response channels.
//   Two-stage pipeline: operand register, then product routed to a per-requester response slot.
//   Sits between HLS compute lanes and the single shared DSP multiplier of the top design.
// PARAMETERS
//   NUM_REQ     4   number of requesters (2..16)
//   DIN_WIDTH   8   operand width, signed two's complement
//   DOUT_WIDTH  16  product width; must equal 2*DIN_WIDTH
//   ID_WIDTH    2   requester index width, $clog2(NUM_REQ) (localparam, not overridable)
// PORTS
//   ap_clk      in   1                     single clock, all logic rising-edge
//   ap_rst_n    in   1                     asynchronous, active-low reset
//   req_valid   in   NUM_REQ               operand request per requester
//   req_ready   out  NUM_REQ               grant; handshake = req_valid[i] & req_ready[i]
//   req_a       in   NUM_REQ*DIN_WIDTH     packed operand A, slice i = [i*DIN_WIDTH +: DIN_WIDTH]
//   req_b       in   NUM_REQ*DIN_WIDTH     packed operand B, same packing
//   rsp_valid   out  NUM_REQ               product available for requester i
//   rsp_ready   in   NUM_REQ               requester i accepts product
//   rsp_data    out  NUM_REQ*DOUT_WIDTH    packed signed product, slice i = [i*DOUT_WIDTH +: DOUT_WIDTH]
//   busy        out  1                     |outstanding (any operation in flight or unread)
// BEHAVIOUR
//   Reset (ap_rst_n=0, async): rr_ptr=0, outstanding=0, s1_valid=0, all rsp_valid=0,
//     rsp_data=0, req_ready=0, busy=0. Any in-flight operation is discarded, never delivered.
//   Eligibility: eligible[i] = req_valid[i] & ~outstanding[i] (registered mask only).
//     A response handshake frees its requester from the NEXT cycle; no same-cycle re-grant.
//   Arbitration: combinational round-robin over eligible, search starting at rr_ptr.
//     At most one req_ready bit high per cycle (one-hot or zero).
//     On grant g: rr_ptr <= (g+1) mod NUM_REQ. No grant: rr_ptr holds.
//     req_ready may depend on req_valid. A requester holds valid/a/b stable until granted.
//   Pipeline, grant in cycle T:
//     end of T:   s1_a, s1_b, s1_id <= operands and index of g; s1_valid<=1; outstanding[g]<=1.
//     T+1:        s1 operands drive the multiplier (combinational).
//     end of T+1: rsp_data[s1_id] <= product; rsp_valid[s1_id] <= 1.
//     Fixed latency: rsp_valid visible in cycle T+2. Throughput 1 grant/cycle across distinct requesters.
//   Response: rsp_valid[i] and rsp_data[i] hold until rsp_valid[i]&rsp_ready[i].
//     At that edge rsp_valid[i]<=0 and outstanding[i]<=0. rsp_data[i] retains its last value.
//   Invariant: at most one operation per requester in flight, so the response slot is always
//     empty when its product arrives. No backpressure into the pipeline; assert this in RTL.
//   Arithmetic: $signed(a)*$signed(b), full 16-bit result, never saturates.
//     -128*-128 = 16'h4000; -128*127 = 16'hC080.
//   Simultaneous events:
//     grant to i and rsp handshake of j!=i in the same cycle: both take effect.
//     rsp_ready high with rsp_valid low: ignored.
//   Reset deasserted mid-burst: arbitration restarts from requester 0.
// STRUCTURE
//   Package top_mul_share_pkg: DIN_WIDTH/DOUT_WIDTH/NUM_REQ defaults,
//     typedef logic signed [7:0] mul_op_t; typedef logic signed [15:0] mul_res_t.
//   Sub-module top_mul_rr_arbiter (NUM_REQ): inputs eligible, rr_ptr; outputs one-hot grant, gnt_idx.
//   Multiplier: one instance of top_mul_8s_8s_16_1_1
//     (din0_WIDTH=8, din1_WIDTH=8, dout_WIDTH=16), the only multiply in the block.
// TESTING
//   1 Single op: req0 a=3,b=-5 in cycle 1 -> req_ready[0]=1 in cycle 1;
//     rsp_valid[0]=1 in cycle 3, rsp_data[0]=16'hFFF1.
//   2 Extremes: a=-128,b=-128 -> 16'h4000; a=-128,b=127 -> 16'hC080; a=0,b=-1 -> 16'h0000.
//   3 All 4 requesting from reset: grants in order 0,1,2,3 on consecutive cycles,
//     one-hot each cycle; responses in cycles 3..6.
//   4 Backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1]/rsp_data[1] stable,
//     req_ready[1]=0 throughout, others keep being served;
//     handshake at cycle N -> req1 grantable at N+1, not N.
//   5 Fairness: req0 and req2 valid continuously -> grants strictly alternate 0,2,0,2
//     while outstanding permits.
//   6 Reset mid-op: ap_rst_n low between grant and response -> rsp_valid never rises,
//     busy=0 immediately, next grant goes to requester 0.

Source files
------------

// File: rtl/top_mul_share_pkg.sv
// Shared types, defaults and helpers for the time-shared signed multiplier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package top_mul_share_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DIN_WIDTH_DEF  = 8;
  localparam int DOUT_WIDTH_DEF = 16;

  typedef logic signed [7:0]  mul_op_t;
  typedef logic signed [15:0] mul_res_t;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/top_mul_8s_8s_16_1_1.sv
// Signed din0 x din1 multiplier producing a full-width product.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module top_mul_8s_8s_16_1_1 #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  // Sign-extend both operands so the product is exact and never wraps.
  assign a_ext = dout_WIDTH'($signed(din0));
  assign b_ext = dout_WIDTH'($signed(din1));
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/top_mul_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after rr_ptr wins.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is zero when nothing is eligible.
module top_mul_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] gnt_idx
);

  logic                found;
  logic [ID_WIDTH:0]   sum;
  logic [ID_WIDTH-1:0] pick;

  // Walk the requesters in rotated order; the first eligible one gets the one-hot grant.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    pick    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
        sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      pick = sum[ID_WIDTH-1:0];
      if (!found && eligible[pick]) begin
        grant[pick] = 1'b1;
        gnt_idx     = pick;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/top_mul_share_ctrl.sv
// Time-shares one signed multiplier among NUM_REQ requesters with round-robin grants.
// Latency: grant in cycle T, product visible on rsp_valid/rsp_data in cycle T+2.
// Backpressure: one op in flight per requester; a held response blocks only its own requester.
module top_mul_share_ctrl
  import top_mul_share_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DOUT_WIDTH-1:0] rsp_data,
  output logic                          busy
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    outstanding;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_hs;
  logic [NUM_REQ-1:0]    s1_dec;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  gnt_vld;
  logic [DIN_WIDTH-1:0]  a_sel;
  logic [DIN_WIDTH-1:0]  b_sel;
  logic                  s1_valid;
  logic [ID_WIDTH-1:0]   s1_id;
  logic [DIN_WIDTH-1:0]  s1_a;
  logic [DIN_WIDTH-1:0]  s1_b;
  logic [DOUT_WIDTH-1:0] product;

  // Only the registered outstanding mask gates eligibility, so a freed slot re-arms next cycle.
  assign eligible = req_valid & ~outstanding;

  top_mul_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .gnt_idx  (gnt_idx)
  );

  // Grants are suppressed while reset is held so nothing is handshaken into a reset pipeline.
  assign req_ready = grant & {NUM_REQ{ap_rst_n}};
  assign gnt_vld   = |req_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign busy      = |outstanding;
  assign s1_dec    = s1_valid ? (NUM_REQ'(1) << s1_id) : '0;

  // One-hot AND-OR mux of the granted requester's operands.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel = a_sel | req_a[i*DIN_WIDTH +: DIN_WIDTH];
        b_sel = b_sel | req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  // Round-robin pointer moves just past the winner; holds when nobody is granted.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= ID_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ));
    end
  end

  // Operand stage: capture the granted operands and owner for the multiplier.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= gnt_vld;
      if (gnt_vld) begin
        s1_id <= gnt_idx;
        s1_a  <= a_sel;
        s1_b  <= b_sel;
      end
    end
  end

  top_mul_8s_8s_16_1_1 #(
    .din0_WIDTH (DIN_WIDTH),
    .din1_WIDTH (DIN_WIDTH),
    .dout_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (s1_a),
    .din1 (s1_b),
    .dout (product)
  );

  // A requester is busy from its grant until its response is consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= (outstanding | req_ready) & ~rsp_hs;
    end
  end

  // Response slots: load the product into the owner's slot, clear valid on handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (rsp_valid & ~rsp_hs) | s1_dec;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s1_dec[i]) begin
          rsp_data[i*DOUT_WIDTH +: DOUT_WIDTH] <= product;
        end
      end
    end
  end

  // The pipeline has no stall path, so a product must always find its slot empty.
  a_slot_free: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(|(s1_dec & rsp_valid)));

  // Never more than one grant per cycle.
  a_onehot_grant: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    $onehot0(req_ready));

endmodule

// File: tb/tb_top_mul_share_ctrl.sv
module tb_top_mul_share_ctrl;
  import top_mul_share_pkg::*;

  localparam int N = 4;

  logic            ap_clk   = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*16-1:0] rsp_data;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  top_mul_share_ctrl dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: per-requester pending op, due cycle, product, last delivered value.
  logic [N-1:0]    m_pend;
  int              m_due  [N];
  mul_res_t        m_prod [N];
  mul_res_t        m_last [N];
  int              m_rr;
  logic [N-1:0]    e_gnt;
  logic [N-1:0]    e_rv;
  logic [N*16-1:0] e_dat;
  int              e_g;
  int              e_i;
  mul_op_t         e_a;
  mul_op_t         e_b;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      m_pend = '0;
      m_rr   = 0;
      for (int i = 0; i < N; i++) begin
        m_due[i]  = 0;
        m_prod[i] = '0;
        m_last[i] = '0;
      end
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
    end else begin
      e_g = -1;
      for (int k = 0; k < N; k++) begin
        e_i = (m_rr + k) % N;
        if (e_g < 0 && req_valid[e_i] && !m_pend[e_i]) e_g = e_i;
      end
      e_gnt = '0;
      if (e_g >= 0) e_gnt[e_g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_rv[i] = m_pend[i] && (cyc >= m_due[i]);
        e_dat[i*16 +: 16] = e_rv[i] ? m_prod[i] : m_last[i];
      end
      chk("req_ready", 64'(req_ready), 64'(e_gnt));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("busy", 64'(busy), 64'(|m_pend));
      chk("rsp_data", rsp_data, e_dat);
      for (int i = 0; i < N; i++) begin
        if (e_rv[i] && rsp_ready[i]) begin
          m_pend[i] = 1'b0;
          m_last[i] = m_prod[i];
        end
      end
      if (e_g >= 0) begin
        e_a = req_a[e_g*8 +: 8];
        e_b = req_b[e_g*8 +: 8];
        m_pend[e_g] = 1'b1;
        m_due[e_g]  = cyc + 2;
        m_prod[e_g] = mul_res_t'(e_a) * mul_res_t'(e_b);
        m_rr        = (e_g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  // One isolated op on requester id: grant now, response two cycles later.
  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid[id]    = 1'b1;
    @(negedge ap_clk);
    chk("single_grant", 64'(req_ready), 64'(1 << id));
    tick();
    req_valid[id] = 1'b0;
    @(negedge ap_clk);
    chk("single_lat1", 64'(rsp_valid[id]), 64'd0);
    tick();
    @(negedge ap_clk);
    chk("single_vld", 64'(rsp_valid[id]), 64'd1);
    chk("single_dat", 64'(rsp_data[id*16 +: 16]), 64'(exp));
    tick();
  endtask

  // Drop each masked valid right after the cycle it is granted in.
  task automatic drain(input logic [N-1:0] mask);
    logic [N-1:0] m;
    logic [N-1:0] gg;
    m = mask;
    for (int t = 0; t < 40; t++) begin
      if (m == '0) break;
      @(negedge ap_clk);
      gg = req_ready & m;
      tick();
      req_valid = req_valid & ~gg;
      m = m & ~gg;
    end
    chk("drain_done", 64'(m), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int srv;
    int ng;
    int gi;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 4'hF;
    ap_rst_n  = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    req_valid = '0;

    // Single op and arithmetic extremes.
    single(0, 8'd3,  8'hFB, 16'hFFF1);
    single(0, 8'h80, 8'h80, 16'h4000);
    single(1, 8'h80, 8'h7F, 16'hC080);
    single(2, 8'h00, 8'hFF, 16'h0000);
    single(3, 8'h7F, 8'h7F, 16'h3F01);

    // All four from reset: grants 0..3 on consecutive cycles, responses two cycles behind.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = 8'(i + 2);
      req_b[i*8 +: 8] = 8'hF0 + 8'(i);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      if (k < 4) chk("all4_grant", 64'(req_ready), 64'(1 << k));
      chk("all4_rsp", 64'(rsp_valid), (k >= 2) ? 64'(1 << (k - 2)) : 64'd0);
      tick();
      if (k < 4) req_valid[k] = 1'b0;
    end

    // Backpressure on requester 1 while 0 and 2 keep being served.
    rsp_ready = 4'b1101;
    req_a[8 +: 8] = 8'd7;
    req_b[8 +: 8] = 8'd9;
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("bp_grant1", 64'(req_ready), 64'h2);
    tick();
    req_a[8 +: 8]  = 8'd11;  req_b[8 +: 8]  = 8'd2;
    req_a[0 +: 8]  = 8'd5;   req_b[0 +: 8]  = 8'hFA;
    req_a[16 +: 8] = 8'hFD;  req_b[16 +: 8] = 8'hFD;
    req_valid = 4'b0111;
    srv = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge ap_clk);
      chk("bp_ready1_low", 64'(req_ready[1]), 64'd0);
      if (j >= 1) begin
        chk("bp_vld_hold", 64'(rsp_valid[1]), 64'd1);
        chk("bp_dat_hold", 64'(rsp_data[16 +: 16]), 64'h003F);
      end
      if ((req_ready & 4'b0101) != '0) srv++;
      tick();
    end
    chk("bp_others_served", 64'(srv >= 6), 64'd1);
    drain(4'b0101);
    repeat (3) tick();
    rsp_ready = 4'hF;
    @(negedge ap_clk);
    chk("bp_no_same_cycle", 64'(req_ready), 64'd0);
    chk("bp_hs_vld", 64'(rsp_valid[1]), 64'd1);
    tick();
    @(negedge ap_clk);
    chk("bp_regrant_next", 64'(req_ready), 64'h2);
    tick();
    req_valid[1] = 1'b0;
    repeat (3) tick();

    // Fairness: 0 and 2 continuously requesting alternate strictly.
    do_reset();
    req_a[0 +: 8]  = 8'd9;   req_b[0 +: 8]  = 8'd9;
    req_a[16 +: 8] = 8'hF6;  req_b[16 +: 8] = 8'd4;
    req_valid = 4'b0101;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      if (req_ready != '0) begin
        gi = (req_ready == 4'b0001) ? 0 : (req_ready == 4'b0100) ? 2 : 9;
        chk("fair_alt", 64'(gi), (ng % 2 == 0) ? 64'd0 : 64'd2);
        ng++;
      end
      tick();
    end
    chk("fair_count", 64'(ng), 64'd8);
    drain(4'b0101);
    repeat (3) tick();

    // Reset between grant and response.
    do_reset();
    req_a[8 +: 8] = 8'd100;
    req_b[8 +: 8] = 8'd3;
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("r6_grant1", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk("r6_busy_pre", 64'(busy), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("r6_busy_rst", 64'(busy), 64'd0);
    chk("r6_vld_rst", 64'(rsp_valid), 64'd0);
    tick();
    tick();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("r6_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    req_valid = 4'hF;
    @(negedge ap_clk);
    chk("r6_restart_0", 64'(req_ready), 64'h1);
    tick();
    req_valid[0] = 1'b0;
    drain(4'b1110);
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
